// File: rtl/sim_ioctl_pkg.sv
// Shared types and defaults for the simulation ioctl download initiator.
package sim_ioctl_pkg;

    localparam int SIM_IOCTL_ADDR_W = 25;

    // IDLE idle | SETUP pre-roll | FETCH take byte | WRITE wait-gated strobe | GAP pulse + spacing | TAIL post-roll
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        FETCH = 3'd2,
        WRITE = 3'd3,
        GAP   = 3'd4,
        TAIL  = 3'd5
    } ioctl_state_e;

    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        int w;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        w = 1;
        while ((1 << w) <= m) w++;
        return w;
    endfunction

endpackage

// File: rtl/sim_ioctl_delay.sv
// Loadable down-counter with a zero flag; times SETUP, GAP and TAIL holds.
module sim_ioctl_delay #(
    parameter int CNT_W = 4
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/sim_ioctl_loader.sv
// ioctl download initiator: turns a valid/ready byte stream into spaced ioctl_wr pulses.
// Optional running byte checksum output enabled by defining SIM_IOCTL_LOADER_CKSUM_EN.
module sim_ioctl_loader
    import sim_ioctl_pkg::*;
#(
    parameter int ADDR_W    = SIM_IOCTL_ADDR_W,
    parameter int SETUP_CYC = 4,
    parameter int WR_GAP    = 2,
    parameter int TAIL_CYC  = 4
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        index,
    input  logic [ADDR_W:0]   length,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    output logic              ioctl_download,
    output logic [7:0]        ioctl_index,
    output logic              ioctl_wr,
    output logic [ADDR_W-1:0] ioctl_addr,
    output logic [7:0]        ioctl_dout,
    input  logic              ioctl_wait,
    output logic              busy,
    output logic              done
`ifdef SIM_IOCTL_LOADER_CKSUM_EN
    ,
    output logic [15:0]       cksum
`endif
);

    localparam int CNT_W = cnt_width(SETUP_CYC - 1, WR_GAP, TAIL_CYC - 1);

    ioctl_state_e      r_state;
    ioctl_state_e      w_state_nxt;
    logic [ADDR_W:0]   r_remaining;

    logic              r_s_ready;
    logic              r_download;
    logic [7:0]        r_index;
    logic              r_wr;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_dout;
    logic              r_busy;
    logic              r_done;

    logic              w_cnt_zero;
    logic              w_cnt_load;
    logic              w_cnt_dec;
    logic [CNT_W-1:0]  w_cnt_val;
    logic              w_start_ok;
    logic              w_wr_fire;
    logic              w_take;
    logic              w_ready_nxt;
    logic              w_busy_nxt;
    logic              w_done_nxt;

    sim_ioctl_delay #(
        .CNT_W (CNT_W)
    ) u_delay (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_val),
        .i_dec      (w_cnt_dec),
        .o_zero     (w_cnt_zero)
    );

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:  if (start) w_state_nxt = SETUP;
            SETUP: if (w_cnt_zero) w_state_nxt = (r_remaining == '0) ? TAIL : FETCH;
            FETCH: if (s_valid && r_s_ready) w_state_nxt = WRITE;
            WRITE: if (!ioctl_wait) w_state_nxt = GAP;
            GAP:   if (w_cnt_zero) w_state_nxt = (r_remaining == '0) ? TAIL : FETCH;
            TAIL:  if (w_cnt_zero) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_start_ok  = (r_state == IDLE) && start;
        w_wr_fire   = (r_state == WRITE) && !ioctl_wait;
        w_take      = (r_state == FETCH) && s_valid && r_s_ready;
        w_cnt_dec   = (r_state == SETUP) || (r_state == GAP) || (r_state == TAIL);
        w_cnt_load  = w_start_ok || w_wr_fire || ((w_state_nxt == TAIL) && (r_state != TAIL));
        if (w_start_ok) begin
            w_cnt_val = CNT_W'(SETUP_CYC - 1);
        end else if (w_wr_fire) begin
            w_cnt_val = CNT_W'(WR_GAP);
        end else begin
            w_cnt_val = CNT_W'(TAIL_CYC - 1);
        end
        w_ready_nxt = (w_state_nxt == FETCH);
        w_busy_nxt  = (w_state_nxt != IDLE);
        w_done_nxt  = (r_state == TAIL) && (w_state_nxt == IDLE);
    end

    // Remaining count drops at the write decision so GAP can choose FETCH/TAIL even with WR_GAP=0.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_s_ready   <= 1'b0;
            r_download  <= 1'b0;
            r_index     <= '0;
            r_wr        <= 1'b0;
            r_addr      <= '0;
            r_dout      <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_remaining <= '0;
        end else begin
            r_s_ready  <= w_ready_nxt;
            r_download <= w_busy_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_wr       <= w_wr_fire;
            if (w_start_ok) begin
                r_index     <= index;
                r_remaining <= length;
                r_addr      <= '0;
            end else begin
                if (w_wr_fire) r_remaining <= r_remaining - 1'b1;
                if (r_wr)      r_addr      <= r_addr + 1'b1;
            end
            if (w_take) r_dout <= s_data;
        end
    end

`ifdef SIM_IOCTL_LOADER_CKSUM_EN
    logic [15:0] r_cksum;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_cksum <= '0;
        end else if (w_start_ok) begin
            r_cksum <= '0;
        end else if (r_wr) begin
            r_cksum <= r_cksum + {8'h00, r_dout};
        end
    end

    assign cksum = r_cksum;
`endif

    assign s_ready        = r_s_ready;
    assign ioctl_download = r_download;
    assign ioctl_index    = r_index;
    assign ioctl_wr       = r_wr;
    assign ioctl_addr     = r_addr;
    assign ioctl_dout     = r_dout;
    assign busy           = r_busy;
    assign done           = r_done;

endmodule
